if_buf_feeder: RTL and testbench
================================

# if_buf_feeder

Streams input-feature (IF) rows from a word-addressed IF memory into the PE's IF input buffer (FIFO). Each word is tagged with row-start and row-end flags in the format the PE's IF read path consumes. The block sits upstream of the IF buffer, on the producer side of the PE's IF interface. It honours FIFO back-pressure and sustains one element per cycle when the FIFO is not full.

## Interface
- DATA_WIDTH, 8, IF element width; equals the PE's IF scratch width
- MEM_ADDR_LEN, 12, IF memory address width
- LEN_WIDTH, 8, width of row length and row count fields

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request to begin a transfer; ignored unless idle
- base_addr  in  MEM_ADDR_LEN  address of element 0 of row 0; sampled with start
- row_stride  in  MEM_ADDR_LEN  address distance between row starts; sampled with start
- row_len  in  LEN_WIDTH  elements per row; sampled with start
- row_count  in  LEN_WIDTH  number of rows; sampled with start
- mem_ren  out  1  IF memory read enable
- mem_raddr  out  MEM_ADDR_LEN  IF memory read address
- mem_rdata  in  DATA_WIDTH  read data, valid exactly 1 cycle after mem_ren
- buf_full  in  1  IF buffer full
- buf_write  out  1  IF buffer push
- buf_wdata  out  DATA_WIDTH+2  {row_start, row_end, data}; bit DATA_WIDTH = row_end, bit DATA_WIDTH+1 = row_start
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse after the last word is pushed

## Operation
- States:
  - IDLE → RUN on start. On the same edge, capture all config and set element counter e=0, row counter r=0, row address ra=base_addr.
  - If row_len==0 or row_count==0, go IDLE → DONE instead, with no reads and no writes.
  - RUN → DRAIN when the last read is issued.
  - DRAIN → DONE when the skid FIFO is empty and no read is in flight.
  - DONE → IDLE unconditionally. done=1 only in DONE.
- Address generation: mem_raddr = ra + e.
  - After each issued read, e increments.
  - When e reaches row_len-1, the next read sets e=0, ra=ra+row_stride, r=r+1.
  - Address arithmetic wraps modulo 2^MEM_ADDR_LEN.
- Tagging: each issued read carries its tag through the pipeline.
  - row_start=1 when e==0.
  - row_end=1 when e==row_len-1.
  - row_len==1 sets both flags.
- Skid FIFO: 2 entries, each DATA_WIDTH+2 bits, written with {tags, mem_rdata} in the cycle mem_rdata is valid.
- Issue rule: mem_ren = (state==RUN) & (occ + inflight − pop < 2).
  - pop = buf_write.
  - inflight = mem_ren registered.
- Push rule: buf_write = (occ>0) & ~buf_full, with buf_wdata = skid head. This is combinational in buf_full.
- busy = (state != IDLE).
- start while busy: ignored, with no effect on counters.
- rst at any time: returns to IDLE, clears counters, skid FIFO and inflight, and drops all outputs to 0. A partially fed row is abandoned; upstream is responsible for flushing the IF buffer.

## Timing
- Reset values: mem_ren=0, mem_raddr=0, buf_write=0, buf_wdata=0, busy=0, done=0.
- Start and first read:
  - start sampled at edge T0.
  - First mem_ren in the cycle after T0.
  - First buf_write 2 cycles after the first mem_ren, provided buf_full=0.
- Throughput: 1 word/cycle with buf_full=0. For N = row_len·row_count words and no stalls, done pulses N+3 cycles after the start cycle.
- buf_full held high: buf_write=0. At most 2 reads are outstanding (skid full), after which mem_ren=0 until space frees. No word is lost or duplicated.
- buf_full falling: buf_write in the same cycle; reads resume the same cycle that occupancy allows.

## Structure
- Shared package holds:
  - the state encoding (IDLE, RUN, DRAIN, DONE);
  - the tag bit positions (ROW_END_BIT = DATA_WIDTH, ROW_START_BIT = DATA_WIDTH+1);
  - the skid depth constant (2).
- One sub-module, feed_skid_fifo: a 2-entry synchronous FIFO with push, pop, occ, head, and asynchronous reset.
- The counters and FSM live in the top module.

## Test plan
- Basic stream: base=0x010, stride=0x020, row_len=3, row_count=2, buf_full=0.
  - Reads at 0x010, 0x011, 0x012, 0x030, 0x031, 0x032 on consecutive cycles.
  - 6 pushes with row_start on pushes 1 and 4, row_end on pushes 3 and 6.
  - done 9 cycles after start.
- Back-pressure: same config with buf_full=1 for cycles 3–8.
  - mem_ren drops after 2 outstanding reads.
  - Pushes resume when buf_full falls; the data sequence is identical to the basic stream.
- Degenerate sizes:
  - row_len=0 → done 1 cycle after start, with zero mem_ren and zero buf_write.
  - row_len=1, row_count=3 → every pushed word has both flags set.
- Address wrap: MEM_ADDR_LEN=12, base=0xFFE, row_len=4 → reads at 0xFFE, 0xFFF, 0x000, 0x001.
- Reset and re-start:
  - rst mid-RUN after 2 pushes → all outputs 0 immediately.
  - A new start then streams correctly from the new base, with no stale skid data pushed.
  - start pulsed while busy is ignored: word count is unchanged.

Source files
------------

// File: rtl/if_buf_feeder_pkg.sv
// Shared constants for the IF buffer feeder: element widths, tag bit positions,
// skid depth and the transfer FSM encoding.
package if_buf_feeder_pkg;

  localparam int DATA_WIDTH    = 8;
  localparam int MEM_ADDR_LEN  = 12;
  localparam int LEN_WIDTH     = 8;
  localparam int ROW_END_BIT   = DATA_WIDTH;
  localparam int ROW_START_BIT = DATA_WIDTH + 1;
  localparam int WORD_WIDTH    = DATA_WIDTH + 2;

  localparam logic [2:0] SKID_DEPTH = 3'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/if_buf_feeder_skid_fifo.sv
// Two-entry skid FIFO absorbing reads already in flight when the IF buffer stalls.
// Same-cycle push and pop are allowed; the caller never pushes into a full FIFO.
module feed_skid_fifo
  import if_buf_feeder_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       occ,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/if_buf_feeder.sv
// Streams strided IF rows from memory into the PE IF buffer, tagging row start/end,
// one word per cycle while the buffer accepts, stalling reads once the skid is committed.
module if_buf_feeder
  import if_buf_feeder_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [MEM_ADDR_LEN-1:0] base_addr,
  input  logic [MEM_ADDR_LEN-1:0] row_stride,
  input  logic [LEN_WIDTH-1:0]    row_len,
  input  logic [LEN_WIDTH-1:0]    row_count,
  output logic                    mem_ren,
  output logic [MEM_ADDR_LEN-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    buf_full,
  output logic                    buf_write,
  output logic [WORD_WIDTH-1:0]   buf_wdata,
  output logic                    busy,
  output logic                    done
);

  state_t                  state;
  state_t                  state_nxt;
  logic [MEM_ADDR_LEN-1:0] cfg_stride;
  logic [MEM_ADDR_LEN-1:0] ra;
  logic [LEN_WIDTH-1:0]    cfg_len_m1;
  logic [LEN_WIDTH-1:0]    cfg_cnt_m1;
  logic [LEN_WIDTH-1:0]    e;
  logic [LEN_WIDTH-1:0]    r;
  logic                    inflight;
  logic                    tag_start_q;
  logic                    tag_end_q;
  logic [WORD_WIDTH-1:0]   skid_in;
  logic [WORD_WIDTH-1:0]   skid_head;
  logic [1:0]              occ;
  logic [2:0]              load;
  logic                    pop;
  logic                    issue;
  logic                    row_last;
  logic                    last_read;
  logic                    empty_size;

  assign pop        = (occ != 2'd0) && !buf_full;
  assign load       = {1'b0, occ} + {2'b0, inflight};
  assign issue      = (state == RUN) && (load < SKID_DEPTH + {2'b0, pop});
  assign row_last   = (e == cfg_len_m1);
  assign last_read  = issue && row_last && (r == cfg_cnt_m1);
  assign empty_size = (row_len == '0) || (row_count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // DRAIN exits on the cycle the final word is popped so done follows the last push directly.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = empty_size ? DONE : RUN;
      RUN:     if (last_read) state_nxt = DRAIN;
      DRAIN:   if (!inflight && (occ == {1'b0, pop})) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_ren   = issue;
    mem_raddr = ra + {{(MEM_ADDR_LEN-LEN_WIDTH){1'b0}}, e};
    buf_write = pop;
    buf_wdata = (occ != 2'd0) ? skid_head : '0;
    busy      = (state != IDLE);
    done      = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_stride <= '0;
      cfg_len_m1 <= '0;
      cfg_cnt_m1 <= '0;
      ra         <= '0;
      e          <= '0;
      r          <= '0;
    end else if ((state == IDLE) && start) begin
      cfg_stride <= row_stride;
      cfg_len_m1 <= row_len - LEN_WIDTH'(1);
      cfg_cnt_m1 <= row_count - LEN_WIDTH'(1);
      ra         <= base_addr;
      e          <= '0;
      r          <= '0;
    end else if (issue) begin
      if (row_last) begin
        e  <= '0;
        ra <= ra + cfg_stride;
        r  <= r + LEN_WIDTH'(1);
      end else begin
        e <= e + LEN_WIDTH'(1);
      end
    end
  end

  // Tags ride alongside the read so they line up with mem_rdata one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight    <= 1'b0;
      tag_start_q <= 1'b0;
      tag_end_q   <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        tag_start_q <= (e == '0);
        tag_end_q   <= row_last;
      end
    end
  end

  always_comb begin
    skid_in                   = '0;
    skid_in[DATA_WIDTH-1:0]   = mem_rdata;
    skid_in[ROW_END_BIT]      = tag_end_q;
    skid_in[ROW_START_BIT]    = tag_start_q;
  end

  feed_skid_fifo #(
    .WIDTH(WORD_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (skid_in),
    .pop       (pop),
    .occ       (occ),
    .head      (skid_head)
  );

endmodule

// File: tb/tb_if_buf_feeder.sv
// Directed and randomized bench for if_buf_feeder against a row/element reference model.
module tb_if_buf_feeder;
  import if_buf_feeder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] base_addr;
  logic [11:0] row_stride;
  logic [7:0]  row_len;
  logic [7:0]  row_count;
  logic        mem_ren;
  logic [11:0] mem_raddr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        buf_full;
  logic        buf_write;
  logic [9:0]  buf_wdata;
  logic        busy;
  logic        done;

  logic [7:0]  ifmem [4096];

  int n_assert = 0;
  int n_fail   = 0;
  int first_push;
  int done_cyc;
  logic ren_at3;

  if_buf_feeder dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .row_stride (row_stride),
    .row_len    (row_len),
    .row_count  (row_count),
    .mem_ren    (mem_ren),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .buf_full   (buf_full),
    .buf_write  (buf_write),
    .buf_wdata  (buf_wdata),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= ifmem[mem_raddr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_ren"},   32'(mem_ren),   32'd0);
    check({tag, "_mem_raddr"}, 32'(mem_raddr), 32'd0);
    check({tag, "_buf_write"}, 32'(buf_write), 32'd0);
    check({tag, "_buf_wdata"}, 32'(buf_wdata), 32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_done"},      32'(done),      32'd0);
  endtask

  // Expected stream: row r, element e reads base + r*stride + e (mod 4096),
  // tagged start at e==0 and end at e==len-1.
  task automatic run_xfer(input logic [11:0] b, input logic [11:0] s,
                          input logic [7:0] len, input logic [7:0] cnt,
                          input int full_lo, input int full_hi, input bit rand_full,
                          input bit busy_start, input int abort_at, input bit chk_time);
    logic [11:0] exp_addr [$];
    logic [9:0]  exp_word [$];
    logic [11:0] a;
    int n;
    int nread, npush, outstanding, max_out, first_read;
    n = int'(len) * int'(cnt);
    for (int ri = 0; ri < int'(cnt); ri++) begin
      for (int ei = 0; ei < int'(len); ei++) begin
        a = b + 12'(ri) * s + 12'(ei);
        exp_addr.push_back(a);
        exp_word.push_back({(ei == 0), (ei == int'(len) - 1), ifmem[a]});
      end
    end
    nread = 0; npush = 0; outstanding = 0; max_out = 0; first_read = -1;
    first_push = -1; done_cyc = -1; ren_at3 = 1'bx;

    @(posedge clk); #1;
    base_addr = b; row_stride = s; row_len = len; row_count = cnt;
    start = 1'b1;
    buf_full = (0 >= full_lo && 0 <= full_hi);
    for (int c = 0; c < 400; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        start = busy_start && (c == 2);
        if (start) begin
          base_addr = 12'h0AA; row_len = 8'd9; row_count = 8'd5;
        end
        buf_full = rand_full ? ($urandom_range(0, 2) == 0) : (c >= full_lo && c <= full_hi);
      end
      @(negedge clk);
      if (mem_ren) begin
        if (first_read < 0) first_read = c;
        if (nread < n) check("raddr", 32'(mem_raddr), 32'(exp_addr[nread]));
        nread++;
        outstanding++;
      end
      if (buf_write) begin
        if (first_push < 0) first_push = c;
        if (npush < n) check("wdata", 32'(buf_wdata), 32'(exp_word[npush]));
        npush++;
        outstanding--;
      end
      if (outstanding > max_out) max_out = outstanding;
      if (c == 3) ren_at3 = mem_ren;
      if (abort_at > 0 && npush == abort_at) begin
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        buf_full = 1'b0;
        return;
      end
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    check("done_seen", 32'(done_cyc >= 0), 32'd1);
    check("read_count", 32'(nread), 32'(n));
    check("push_count", 32'(npush), 32'(n));
    check("max_outstanding_le2", 32'(max_out <= 2), 32'd1);
    if (chk_time) check("done_cycle", 32'(done_cyc), (n == 0) ? 32'd1 : 32'(n + 3));
    if (n > 0) check("first_read_cycle", 32'(first_read), 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    buf_full = 1'b0;
    @(negedge clk);
    check("idle_after_done", {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ifmem[i] = 8'($urandom);
    rst = 1'b1; start = 1'b0; buf_full = 1'b0;
    base_addr = '0; row_stride = '0; row_len = '0; row_count = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    run_xfer(12'h010, 12'h020, 8'd3, 8'd2, -1, -1, 1'b0, 1'b0, 0, 1'b1);
    check("basic_first_push", 32'(first_push), 32'd3);

    run_xfer(12'h010, 12'h020, 8'd3, 8'd2, 3, 8, 1'b0, 1'b0, 0, 1'b0);
    check("bp_ren_cycle3", 32'(ren_at3), 32'd0);
    check("bp_first_push", 32'(first_push), 32'd9);

    run_xfer(12'h100, 12'h010, 8'd0, 8'd2, -1, -1, 1'b0, 1'b0, 0, 1'b1);
    run_xfer(12'h100, 12'h010, 8'd4, 8'd0, -1, -1, 1'b0, 1'b0, 0, 1'b1);
    run_xfer(12'h200, 12'h005, 8'd1, 8'd3, -1, -1, 1'b0, 1'b0, 0, 1'b1);
    run_xfer(12'hFFE, 12'h100, 8'd4, 8'd1, -1, -1, 1'b0, 1'b0, 0, 1'b1);

    run_xfer(12'h200, 12'h040, 8'd4, 8'd3, -1, -1, 1'b0, 1'b0, 2, 1'b0);
    run_xfer(12'h300, 12'h008, 8'd3, 8'd3, -1, -1, 1'b0, 1'b0, 0, 1'b1);

    run_xfer(12'h050, 12'h010, 8'd2, 8'd2, -1, -1, 1'b0, 1'b1, 0, 1'b1);

    for (int k = 0; k < 8; k++) begin
      run_xfer(12'($urandom), 12'($urandom), 8'($urandom_range(1, 5)), 8'($urandom_range(1, 4)),
               -1, -1, 1'b1, 1'b0, 0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
